// File: rtl/fir_l3_pkg.sv
// Shared types and constants for the 3-parallel FIR output path.
// Lanes are ordered oldest (index 0) to newest (index 2) in time.
package fir_l3_pkg;
    localparam int DATA_OUT_WIDTH = 64;
    localparam int LANES          = 3;

    typedef logic signed [DATA_OUT_WIDTH-1:0] sample_t;
    typedef sample_t [LANES-1:0]              block_t;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2
    } lane_e;
endpackage

// File: rtl/fir_block_fifo.sv
// Block-wide FIFO: each entry holds all three lanes of one filter output block.
// Full/empty come from the occupancy count, so pointers simply wrap.
module fir_block_fifo
    import fir_l3_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [LANES-1:0][W-1:0]   din,
    output logic [LANES-1:0][W-1:0]   dout,
    output logic                      full,
    output logic                      empty,
    output logic [LW-1:0]             level
);
    logic [LANES-1:0][W-1:0] mem [DEPTH];
    logic [PW-1:0]           rptr;
    logic [PW-1:0]           wptr;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rptr];

    // Payload needs no reset: it is never observed while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr  <= '0;
            wptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/fir_l3_output_serializer.sv
// Turns 3-lane FIR output blocks into one time-ordered serial stream with
// valid/ready backpressure; blocks arriving while full are dropped and flagged.
module fir_l3_output_serializer
    import fir_l3_pkg::*;
#(
    parameter int DATA_OUT_WIDTH = 64,
    parameter int DEPTH          = 4,
    parameter int CNT_WIDTH      = 32,
    localparam int LW            = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [DATA_OUT_WIDTH-1:0] blk_data_1,
    input  logic [DATA_OUT_WIDTH-1:0] blk_data_2,
    input  logic [DATA_OUT_WIDTH-1:0] blk_data_3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_OUT_WIDTH-1:0] out_data,
    output logic [1:0]                out_lane,
    output logic                      overflow,
    input  logic                      clear_overflow,
    output logic [LW-1:0]             level,
    output logic [CNT_WIDTH-1:0]      sample_count
);
    logic [LANES-1:0][DATA_OUT_WIDTH-1:0] head;
    logic                                 full;
    logic                                 empty;
    logic                                 push;
    logic                                 pop;
    logic                                 xfer;
    lane_e                                lane;
    lane_e                                lane_nxt;

    assign blk_ready = !full;
    assign push      = blk_valid && !full;
    assign out_valid = !empty;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (lane == LANE2);
    assign out_lane  = lane;

    fir_block_fifo #(
        .W     (DATA_OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     ({blk_data_3, blk_data_2, blk_data_1}),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lane <= LANE0;
        else          lane <= lane_nxt;
    end

    always_comb begin
        lane_nxt = lane;
        if (empty) begin
            lane_nxt = LANE0;
        end else if (xfer) begin
            case (lane)
                LANE0:   lane_nxt = LANE1;
                LANE1:   lane_nxt = LANE2;
                default: lane_nxt = LANE0;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (lane)
                LANE0:   out_data = head[0];
                LANE1:   out_data = head[1];
                LANE2:   out_data = head[2];
                default: out_data = '0;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow     <= 1'b0;
            sample_count <= '0;
        end else begin
            if (blk_valid && !blk_ready) overflow <= 1'b1;
            else if (clear_overflow)     overflow <= 1'b0;
            if (xfer) sample_count <= sample_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fir_l3_output_serializer.sv
// Scoreboard bench: stimulus queues expected samples, a negedge monitor
// compares every serial transfer and held output against the queue head.
module tb_fir_l3_output_serializer;
    localparam int W  = 64;
    localparam int LW = 3;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   lane;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          blk_valid;
    logic          blk_ready;
    logic [W-1:0]  blk_data_1, blk_data_2, blk_data_3;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    out_lane;
    logic          overflow;
    logic          clear_overflow;
    logic [LW-1:0] level;
    logic [31:0]   sample_count;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [W-1:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;

    fir_l3_output_serializer #(.DATA_OUT_WIDTH(W), .DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_data_1     (blk_data_1),
        .blk_data_2     (blk_data_2),
        .blk_data_3     (blk_data_3),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_lane       (out_lane),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .level          (level),
        .sample_count   (sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_blk(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input bit accept);
        blk_valid  = 1'b1;
        blk_data_1 = a;
        blk_data_2 = b;
        blk_data_3 = c;
        if (accept) begin
            q.push_back('{data: a, lane: 2'd0});
            q.push_back('{data: b, lane: 2'd1});
            q.push_back('{data: c, lane: 2'd2});
        end
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d samples never emitted, expected 0 left", name, q.size());
            q.delete();
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid&&ready here.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                if (out_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got data %h lane %0d, expected no sample", out_data, out_lane);
                end
            end else begin
                chk(out_ready ? "out_data" : "held_data", out_data, q[0].data);
                chk(out_ready ? "out_lane" : "held_lane", W'(out_lane), W'(q[0].lane));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        blk_valid      = 1'b0;
        blk_data_1     = '0;
        blk_data_2     = '0;
        blk_data_3     = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", W'(out_lane), 0);
        chk("rst_blk_ready", W'(blk_ready), 1);
        chk("rst_level", W'(level), 0);
        chk("rst_sample_count", W'(sample_count), 0);
        chk("rst_overflow", W'(overflow), 0);
        reset_n = 1'b1;
        tick();

        // 1: single block, free-running output
        out_ready = 1'b1;
        push_blk(64'd1, -64'sd2, 64'd3, 1'b1);
        chk("t1_latency_valid", W'(out_valid), 1);
        chk("t1_latency_lane", W'(out_lane), 0);
        drain("t1_drain");
        chk("t1_sample_count", W'(sample_count), 3);
        chk("t1_level", W'(level), 0);

        // 2: fill under backpressure, then drop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_blk(W'(16 * i + 1), W'(16 * i + 2), W'(16 * i + 3), 1'b1);
        chk("t2_level_full", W'(level), 4);
        chk("t2_blk_ready", W'(blk_ready), 0);
        chk("t2_overflow_pre", W'(overflow), 0);
        push_blk(64'd99, 64'd98, 64'd97, 1'b0);
        chk("t2_overflow_set", W'(overflow), 1);
        chk("t2_level_after_drop", W'(level), 4);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t2_overflow_clr", W'(overflow), 0);

        // 3: drop coincides with clear
        clear_overflow = 1'b1;
        push_blk(64'd55, 64'd56, 64'd57, 1'b0);
        clear_overflow = 1'b0;
        chk("t3_set_wins", W'(overflow), 1);
        out_ready = 1'b1;
        drain("t3_drain");
        chk("t3_sample_count", W'(sample_count), 15);
        chk("t3_level", W'(level), 0);

        // 4: stalls on full-scale signed values
        out_ready = 1'b0;
        push_blk(MAXV, MINV, 64'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1'b1;
        drain("t4_drain");
        chk("t4_sample_count", W'(sample_count), 18);

        // 5: one block every third cycle never backs up
        for (int i = 0; i < 5; i++) begin
            push_blk(W'(100 + i), -W'(200 + i), W'(300 + i), 1'b1);
            chk("t5_level_le1", W'(level <= 1), 1);
            tick();
            tick();
        end
        drain("t5_drain");
        chk("t5_overflow", W'(overflow), 1);
        chk("t5_sample_count", W'(sample_count), 33);

        // 6: reset with lane 2 of a block still pending
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        push_blk(64'd10, 64'd11, 64'd12, 1'b1);
        tick();
        tick();
        chk("t6_pre_lane", W'(out_lane), 2);
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("t6_rst_valid", W'(out_valid), 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_level", W'(level), 0);
        chk("t6_rst_lane", W'(out_lane), 0);
        chk("t6_rst_overflow", W'(overflow), 0);
        tick();
        reset_n = 1'b1;
        tick();
        push_blk(64'd9, 64'd8, 64'd7, 1'b1);
        chk("t6_first_data", out_data, 64'd9);
        drain("t6_drain");
        chk("t6_sample_count", W'(sample_count), 3);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
